// File: rtl/gate_tt_sequencer.sv
// Truth-table sweep engine: drives each input vector to a gate, samples it after SETTLE cycles, compares with EXP_TT.
// Latency: SETTLE+1 cycles per vector; done pulses 2**N_IN*(SETTLE+1)+1 cycles after start. start ignored unless idle.
// Optional GATE_TT_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module gate_tt_sequencer #(
  parameter int                    N_IN   = 1,
  parameter int                    SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0]  EXP_TT = 2'b01
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [N_IN-1:0]         gate_in,
  input  logic                    gate_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [N_IN-1:0]         fail_idx,
  output logic [(1<<N_IN)-1:0]    tt
);

  localparam int NV = 1 << N_IN;
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [N_IN-1:0]   gate_in_d;
  logic              busy_d, done_d, pass_d;
  logic [N_IN-1:0]   fail_idx_d;
  logic [NV-1:0]     tt_d;
  logic              mismatch;
  logic              stop_now;

  assign mismatch = (gate_out != EXP_TT[idx_q]);

`ifdef GATE_TT_STOP_ON_FAIL_EN
  assign stop_now = mismatch && !err_q;
`else
  assign stop_now = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    gate_in_d  = gate_in;
    busy_d     = busy;
    done_d     = 1'b0;
    pass_d     = pass;
    fail_idx_d = fail_idx;
    tt_d       = tt;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d      = '0;
          gate_in_d  = '0;
          cnt_d      = '0;
          tt_d       = '0;
          err_d      = 1'b0;
          fail_idx_d = '0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        tt_d[idx_q] = gate_out;
        if (mismatch && !err_q) begin
          err_d      = 1'b1;
          fail_idx_d = idx_q;
        end
        // gate_in is left on the last driven vector when the sweep ends
        if (idx_q == IDX_LAST || stop_now) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = ~err_d;
        end else begin
          idx_d     = idx_q + 1'b1;
          gate_in_d = idx_q + 1'b1;
          cnt_d     = '0;
          state_d   = S_SETTLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      gate_in  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_idx <= '0;
      tt       <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      gate_in  <= gate_in_d;
      busy     <= busy_d;
      done     <= done_d;
      pass     <= pass_d;
      fail_idx <= fail_idx_d;
      tt       <= tt_d;
    end
  end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Bench for gate_tt_sequencer: several gate configurations, directed and random sweeps against a truth-table model.
module tb_gate_tt_sequencer;

  localparam int ND = 5;
  localparam int          NIN  [ND] = '{1, 2, 2, 3, 4};
  localparam int          STL  [ND] = '{1, 2, 1, 3, 1};
  localparam logic [15:0] EXPV [ND] = '{16'h0001, 16'h0007, 16'h0008, 16'h0096, 16'h8000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_v [ND];
  logic [15:0] act     [ND];
  logic [3:0]  gin     [ND];
  logic [3:0]  fidx    [ND];
  logic [15:0] ttv     [ND];
  logic        busy_v  [ND];
  logic        done_v  [ND];
  logic        pass_v  [ND];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar i = 0; i < ND; i++) begin : g_dut
    localparam int W = NIN[i];
    localparam int T = 1 << W;
    logic [W-1:0] gi;
    logic [W-1:0] fi;
    logic [T-1:0] t;
    logic         go, b, dn, p;

    assign go = act[i][gi];

    gate_tt_sequencer #(
      .N_IN   (W),
      .SETTLE (STL[i]),
      .EXP_TT (EXPV[i][T-1:0])
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_v[i]),
      .gate_in  (gi),
      .gate_out (go),
      .busy     (b),
      .done     (dn),
      .pass     (p),
      .fail_idx (fi),
      .tt       (t)
    );

    assign gin[i]    = 4'(gi);
    assign fidx[i]   = 4'(fi);
    assign ttv[i]    = 16'(t);
    assign busy_v[i] = b;
    assign done_v[i] = dn;
    assign pass_v[i] = p;
  end

  function automatic logic [15:0] vec_mask(input int d);
    logic [15:0] m = '0;
    for (int k = 0; k < (1 << NIN[d]); k++) m[k] = 1'b1;
    return m;
  endfunction

  // Reference: first mismatching vector, table truncated at the last visited vector, done cycle from visit count.
  task automatic model(input int d, input logic [15:0] a, output logic [15:0] e_tt, output int e_fi,
                       output bit e_pass, output int e_done, output int e_gin);
    int  n    = 1 << NIN[d];
    bit  mism = 0;
    int  last;
    e_fi = 0;
    for (int k = 0; k < n; k++) begin
      if (a[k] !== EXPV[d][k] && !mism) begin
        mism = 1;
        e_fi = k;
      end
    end
    e_pass = !mism;
`ifdef GATE_TT_STOP_ON_FAIL_EN
    last = mism ? e_fi : n - 1;
`else
    last = n - 1;
`endif
    e_tt = '0;
    for (int k = 0; k <= last; k++) e_tt[k] = a[k];
    e_done = (last + 1) * (STL[d] + 1) + 1;
    e_gin  = last;
  endtask

  task automatic do_sweep(input int d, input logic [15:0] a, input bit noise, input string tag);
    logic [15:0] e_tt;
    int          e_fi, e_done, e_gin;
    bit          e_pass;
    int          first = 0, ndone = 0;
    bit          busy_ok = 1, seq_ok = 1;
    logic [15:0] c_tt = '0;
    logic [3:0]  c_fi = '0, c_gin = '0;
    logic        c_pass = 1'b0;
    int          s1 = STL[d] + 1;
    model(d, a, e_tt, e_fi, e_pass, e_done, e_gin);
    act[d] = a;
    @(negedge clk);
    start_v[d] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= e_done + 2; c++) begin
      @(negedge clk);
      if (done_v[d] === 1'b1) begin
        ndone++;
        if (first == 0) first = c;
      end
      if (busy_v[d] !== (c < e_done)) busy_ok = 0;
      if (c < e_done && gin[d] !== 4'((c - 1) / s1)) seq_ok = 0;
      if (c == e_done) begin
        c_tt = ttv[d]; c_fi = fidx[d]; c_pass = pass_v[d]; c_gin = gin[d];
      end
      start_v[d] = noise && (c < e_done) && ($urandom_range(0, 2) == 0);
    end
    start_v[d] = 1'b0;

    n_cmp++; if (first !== e_done) begin n_bad++; $display("FAIL %s done_cycle: got %0d want %0d", tag, first, e_done); end
    n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL %s done_count: got %0d want 1", tag, ndone); end
    n_cmp++; if (!busy_ok) begin n_bad++; $display("FAIL %s busy_window: got bad want high cycles 1..%0d", tag, e_done - 1); end
    n_cmp++; if (!seq_ok) begin n_bad++; $display("FAIL %s gate_in_seq: got bad want vector (c-1)/%0d", tag, s1); end
    n_cmp++; if (c_pass !== e_pass) begin n_bad++; $display("FAIL %s pass: got %0b want %0b", tag, c_pass, e_pass); end
    n_cmp++; if (c_fi !== 4'(e_fi)) begin n_bad++; $display("FAIL %s fail_idx: got %0d want %0d", tag, c_fi, e_fi); end
    n_cmp++; if (c_tt !== e_tt) begin n_bad++; $display("FAIL %s tt: got %h want %h", tag, c_tt, e_tt); end
    n_cmp++; if (c_gin !== 4'(e_gin)) begin n_bad++; $display("FAIL %s gate_in_end: got %0d want %0d", tag, c_gin, e_gin); end
    n_cmp++;
    if (pass_v[d] !== e_pass || fidx[d] !== 4'(e_fi) || ttv[d] !== e_tt || busy_v[d] !== 1'b0) begin
      n_bad++;
      $display("FAIL %s hold: got pass=%0b fi=%0d tt=%h busy=%0b want pass=%0b fi=%0d tt=%h busy=0",
               tag, pass_v[d], fidx[d], ttv[d], busy_v[d], e_pass, e_fi, e_tt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      n_cmp++;
      if (gin[d] !== 4'd0 || fidx[d] !== 4'd0 || ttv[d] !== 16'd0 ||
          busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || pass_v[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_dut%0d: got gi=%0d fi=%0d tt=%h busy=%0b done=%0b pass=%0b want all 0",
                 d, gin[d], fidx[d], ttv[d], busy_v[d], done_v[d], pass_v[d]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    do_sweep(0, 16'h0001, 1'b0, "T1_inverter");
    do_sweep(1, 16'h0000, 1'b0, "T2_nand_stuck0");
    do_sweep(2, 16'h000E, 1'b0, "T4_and_vs_or");
    do_sweep(3, 16'h0096, 1'b0, "xor3_good");
    do_sweep(4, 16'h8000, 1'b0, "and4_good");
    do_sweep(4, 16'h0000, 1'b0, "and4_last_bad");
  endtask

  task automatic test_midsweep_reset();
    int seen = 0;
    act[0] = 16'h0001;
    @(negedge clk); start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); start_v[0] = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (gin[0] !== 4'd0 || fidx[0] !== 4'd0 || ttv[0] !== 16'd0 ||
        busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || pass_v[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL midsweep_reset: got gi=%0d fi=%0d tt=%h busy=%0b done=%0b pass=%0b want all 0",
               gin[0], fidx[0], ttv[0], busy_v[0], done_v[0], pass_v[0]);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL post_reset_quiet: got %0d active cycles want 0", seen); end
    do_sweep(0, 16'h0001, 1'b0, "T5_after_reset");
  endtask

  task automatic test_restart_ignored();
    int d1 = 0, d2 = 0, nd = 0;
    logic p12 = 1'b0;
    act[0] = 16'h0001;
    @(negedge clk); start_v[0] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) begin
        nd++;
        if (d1 == 0) d1 = c; else if (d2 == 0) d2 = c;
      end
      if (c == 12) p12 = pass_v[0];
      start_v[0] = (c == 2 || c == 5 || c == 7);
    end
    start_v[0] = 1'b0;
    n_cmp++; if (nd !== 2) begin n_bad++; $display("FAIL T6_done_count: got %0d want 2", nd); end
    n_cmp++; if (d1 !== 5) begin n_bad++; $display("FAIL T6_first_done: got %0d want 5", d1); end
    n_cmp++; if (d2 !== 12) begin n_bad++; $display("FAIL T6_second_done: got %0d want 12", d2); end
    n_cmp++; if (p12 !== 1'b1) begin n_bad++; $display("FAIL T6_pass: got %0b want 1", p12); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 30; r++) begin
      int          d = $urandom_range(0, ND - 1);
      logic [15:0] a;
      if ($urandom_range(0, 2) == 0) a = EXPV[d];
      else a = 16'($urandom) & vec_mask(d);
      do_sweep(d, a, 1'($urandom_range(0, 1)), $sformatf("rand%0d_dut%0d", r, d));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      start_v[d] = 1'b0;
      act[d]     = '0;
    end
    test_reset();
    test_directed();
    test_midsweep_reset();
    test_restart_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
